// File: rtl/hazard_stall_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_stall_controller_pkg: shared RV32 opcode and register consts  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hazard_stall_controller_pkg;

  localparam logic [6:0] c_OPC_LW    = 7'b0000011;
  localparam logic [6:0] c_OPC_SW    = 7'b0100011;
  localparam logic [6:0] c_OPC_ADDI  = 7'b0010011;
  localparam logic [6:0] c_OPC_ARITH = 7'b0110011;
  localparam logic [6:0] c_OPC_ECALL = 7'b1110011;

  localparam logic [4:0] c_REG_X0  = 5'd0;
  localparam logic [4:0] c_REG_X17 = 5'd17;

endpackage
`default_nettype wire

// File: rtl/hazard_stall_controller_operand_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_operand_decode: which source registers the ID instruction uses |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hazard_operand_decode
  import hazard_stall_controller_pkg::*;
(
  input  logic [31:0] id_inst,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        is_ecall,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic [6:0] w_opcode;
  logic       w_unused_bits;

  assign w_opcode      = id_inst[6:0];
  assign rs1           = id_inst[19:15];
  assign rs2           = id_inst[24:20];
  assign w_unused_bits = ^{id_inst[31:25], id_inst[14:7]};

  // ECALL reads x17 implicitly; its dependency is handled by the top, not via rs1/rs2
  always_comb begin
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    is_ecall = 1'b0;
    case (w_opcode)
      c_OPC_LW, c_OPC_ADDI: use_rs1 = 1'b1;
      c_OPC_SW, c_OPC_ARITH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      c_OPC_ECALL: is_ecall = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_stall_controller: load-use stall and ECALL drain/halt FSM      |
// | Optional stall counter: HAZARD_STALL_COUNT_EN.            Rev 1.0    |
// +----------------------------------------------------------------------+
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] id_inst,
  input  logic        id_x17_is_10,
  input  logic        idex_mem_read,
  input  logic        idex_reg_write,
  input  logic [4:0]  idex_rd,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        halt,
  output logic [31:0] stall_cycles
);

  localparam logic [1:0] c_RUN    = 2'd0;
  localparam logic [1:0] c_DRAIN  = 2'd1;
  localparam logic [1:0] c_HALTED = 2'd2;

  localparam int                 c_CNT_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(DRAIN_CYCLES - 1);

  logic               w_use_rs1, w_use_rs2, w_is_ecall;
  logic [4:0]         w_rs1, w_rs2;
  logic               w_load_use, w_ecall_dep, w_stall;
  logic [1:0]         r_state, w_next_state;
  logic [c_CNT_W-1:0] r_cnt, w_next_cnt;
  logic               r_halt, w_next_halt;
  logic               w_pc_write, w_ifid_write, w_bubble;

  hazard_operand_decode u_decode (
    .id_inst  (id_inst),
    .use_rs1  (w_use_rs1),
    .use_rs2  (w_use_rs2),
    .is_ecall (w_is_ecall),
    .rs1      (w_rs1),
    .rs2      (w_rs2)
  );

  assign w_load_use  = idex_mem_read && (idex_rd != c_REG_X0) &&
                       ((w_use_rs1 && (w_rs1 == idex_rd)) || (w_use_rs2 && (w_rs2 == idex_rd)));
  // x17 cannot be forwarded into the halt check yet, so wait for the writer to leave ID/EX
  assign w_ecall_dep = w_is_ecall && idex_reg_write && (idex_rd == c_REG_X17);
  assign w_stall     = w_load_use || w_ecall_dep;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_RUN;
      r_cnt   <= '0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_halt  <= w_next_halt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_halt  = r_halt;
    w_pc_write   = 1'b0;
    w_ifid_write = 1'b0;
    w_bubble     = 1'b1;
    case (r_state)
      c_RUN: begin
        if (w_stall) begin
          w_next_state = c_RUN;
        end else if (w_is_ecall && id_x17_is_10) begin
          w_next_state = c_DRAIN;
          w_next_cnt   = c_CNT_INIT;
        end else begin
          w_pc_write   = 1'b1;
          w_ifid_write = 1'b1;
          w_bubble     = 1'b0;
        end
      end
      c_DRAIN: begin
        if (r_cnt == '0) begin
          w_next_state = c_HALTED;
          w_next_halt  = 1'b1;
        end else begin
          w_next_cnt = r_cnt - c_CNT_W'(1);
        end
      end
      c_HALTED: w_next_state = c_HALTED;
      default:  w_next_state = c_RUN;
    endcase
  end

  // Front end stays frozen for as long as reset is held, independent of the FSM
  assign pc_write    = reset_n && w_pc_write;
  assign ifid_write  = reset_n && w_ifid_write;
  assign idex_bubble = !reset_n || w_bubble;
  assign halt        = r_halt;

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
    end else if ((r_state == c_RUN) && w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_stall_controller: directed stimulus with a behavioural model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hazard_stall_controller;

  localparam int DRAIN = 3;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic [31:0] id_inst;
  logic        id_x17_is_10;
  logic        idex_mem_read;
  logic        idex_reg_write;
  logic [4:0]  idex_rd;
  logic        pc_write, ifid_write, idex_bubble, halt;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  hazard_stall_controller #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .id_inst        (id_inst),
    .id_x17_is_10   (id_x17_is_10),
    .idex_mem_read  (idex_mem_read),
    .idex_reg_write (idex_reg_write),
    .idex_rd        (idex_rd),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .idex_bubble    (idex_bubble),
    .halt           (halt),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'd0, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  // Model: the halting ECALL leaves ID at edge leave_edge; the front end is frozen
  // from then on, and halt is visible once DRAIN further edges have elapsed.
  int          edge_no    = 0;
  int          leave_edge = -1;
  logic [31:0] e_cnt      = 32'd0;

  initial begin
    logic       take, count_it, e_pc, e_if, e_bub, e_halt;
    logic [6:0] opc;
    logic [4:0] s1, s2;
    logic       u1, u2, lu, ed;
    forever begin
      @(negedge clk);
      take = 1'b0; count_it = 1'b0; e_halt = 1'b0;
      e_pc = 1'b0; e_if = 1'b0; e_bub = 1'b1;
      if (!reset_n) begin
        leave_edge = -1;
        e_cnt      = 32'd0;
      end else if (leave_edge >= 0) begin
        e_halt = (edge_no - leave_edge) >= DRAIN;
      end else begin
        opc = id_inst[6:0];
        s1  = id_inst[19:15];
        s2  = id_inst[24:20];
        u1  = (opc == 7'b0000011) || (opc == 7'b0010011) || (opc == 7'b0100011) || (opc == 7'b0110011);
        u2  = (opc == 7'b0100011) || (opc == 7'b0110011);
        lu  = idex_mem_read && (idex_rd != 0) && ((u1 && s1 == idex_rd) || (u2 && s2 == idex_rd));
        ed  = (opc == 7'b1110011) && idex_reg_write && (idex_rd == 5'd17);
        if (lu || ed) count_it = 1'b1;
        else if ((opc == 7'b1110011) && id_x17_is_10) take = 1'b1;
        else begin e_pc = 1'b1; e_if = 1'b1; e_bub = 1'b0; end
      end
      chk("m_pc_write", {31'd0, pc_write}, {31'd0, e_pc});
      chk("m_ifid_write", {31'd0, ifid_write}, {31'd0, e_if});
      chk("m_idex_bubble", {31'd0, idex_bubble}, {31'd0, e_bub});
      chk("m_halt", {31'd0, halt}, {31'd0, e_halt});
`ifdef HAZARD_STALL_COUNT_EN
      chk("m_stall_cycles", stall_cycles, e_cnt);
`else
      chk("m_stall_cycles", stall_cycles, 32'd0);
`endif
      @(posedge clk);
      edge_no++;
      if (!reset_n) begin
        leave_edge = -1;
        e_cnt      = 32'd0;
      end else begin
        if (take) leave_edge = edge_no;
        if (count_it && e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 32'd1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic mr, input logic rw,
                       input logic [4:0] rd, input logic x17);
    id_inst = inst; idex_mem_read = mr; idex_reg_write = rw; idex_rd = rd; id_x17_is_10 = x17;
  endtask

  task automatic lit_front(input string name, input logic pc, input logic bub);
    chk({name, "_pc"}, {31'd0, pc_write}, {31'd0, pc});
    chk({name, "_ifid"}, {31'd0, ifid_write}, {31'd0, pc});
    chk({name, "_bub"}, {31'd0, idex_bubble}, {31'd0, bub});
  endtask

  initial begin
    reset_n = 1'b1;
    drive(NOP, 1'b0, 1'b0, 5'd0, 1'b0);
    #1 reset_n = 1'b0;
    @(negedge clk);
    lit_front("reset", 1'b0, 1'b1);
    chk("reset_halt", {31'd0, halt}, 32'd0);
    chk("reset_cnt", stall_cycles, 32'd0);
    cyc();
    reset_n = 1'b1;
    drive(NOP, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk); lit_front("idle", 1'b1, 1'b0); cyc();

    // load-use against ADD, three times, each followed by the bubble cycle
    for (int i = 0; i < 3; i++) begin
      drive(r_add(5'd6, 5'd5, 5'd7), 1'b1, 1'b1, 5'd5, 1'b0);
      @(negedge clk); lit_front("lu_add", 1'b0, 1'b1); cyc();
      drive(r_add(5'd6, 5'd5, 5'd7), 1'b0, 1'b0, 5'd0, 1'b0);
      @(negedge clk); lit_front("lu_after", 1'b1, 1'b0); cyc();
    end
    drive(NOP, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
`ifdef HAZARD_STALL_COUNT_EN
    chk("cnt_three", stall_cycles, 32'd3);
`else
    chk("cnt_off", stall_cycles, 32'd0);
`endif
    cyc();

    drive(r_add(5'd1, 5'd0, 5'd0), 1'b1, 1'b1, 5'd0, 1'b0);
    @(negedge clk); lit_front("x0", 1'b1, 1'b0); cyc();
    drive(addi(5'd1, 5'd6, 12'd0), 1'b1, 1'b1, 5'd5, 1'b0);
    @(negedge clk); lit_front("addi_other", 1'b1, 1'b0); cyc();
    drive(sw(5'd2, 5'd5), 1'b1, 1'b1, 5'd5, 1'b0);
    @(negedge clk); lit_front("sw_rs2", 1'b0, 1'b1); cyc();
    drive(addi(5'd1, 5'd6, 12'd5), 1'b1, 1'b1, 5'd5, 1'b0);
    @(negedge clk); lit_front("addi_rs2unused", 1'b1, 1'b0); cyc();
    drive(lw(5'd3, 5'd5), 1'b1, 1'b1, 5'd5, 1'b0);
    @(negedge clk); lit_front("lw_rs1", 1'b0, 1'b1); cyc();

    // halting ECALL, no dependency
    drive(ECALL, 1'b0, 1'b0, 5'd0, 1'b1);
    @(negedge clk); lit_front("ecall", 1'b0, 1'b1); cyc();
    for (int i = 1; i <= 14; i++) begin
      drive(NOP, 1'b0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      if (i == 3) chk("halt_early", {31'd0, halt}, 32'd0);
      if (i == 4) chk("halt_rise", {31'd0, halt}, 32'd1);
      if (i == 14) begin
        chk("halt_sticky", {31'd0, halt}, 32'd1);
        lit_front("halted", 1'b0, 1'b1);
      end
      cyc();
    end
    reset_n = 1'b0;
    @(negedge clk); chk("rst_clear_halt", {31'd0, halt}, 32'd0); cyc();
    reset_n = 1'b1;

    // ECALL waiting on an x17 writer in ID/EX
    drive(ECALL, 1'b0, 1'b1, 5'd17, 1'b1);
    @(negedge clk); lit_front("ecall_dep", 1'b0, 1'b1); cyc();
    drive(ECALL, 1'b0, 1'b0, 5'd0, 1'b1);
    @(negedge clk); chk("ecall2_halt", {31'd0, halt}, 32'd0); cyc();
    for (int i = 1; i <= 5; i++) begin
      drive(NOP, 1'b0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      if (i == 4) chk("dep_halt_rise", {31'd0, halt}, 32'd1);
      cyc();
    end
    reset_n = 1'b0; cyc(); reset_n = 1'b1;

    drive(ECALL, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk); lit_front("ecall_nohalt", 1'b1, 1'b0); cyc();
    for (int i = 0; i < 5; i++) begin
      drive(NOP, 1'b0, 1'b0, 5'd0, 1'b0);
      @(negedge clk); chk("nohalt", {31'd0, halt}, 32'd0); cyc();
    end

    // reset in the middle of the drain
    drive(ECALL, 1'b0, 1'b0, 5'd0, 1'b1); cyc();
    drive(NOP, 1'b0, 1'b0, 5'd0, 1'b0); cyc(); cyc();
    reset_n = 1'b0;
    @(negedge clk);
    lit_front("mid_rst", 1'b0, 1'b1);
    chk("mid_rst_halt", {31'd0, halt}, 32'd0);
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lit_front("post_rst", 1'b1, 1'b0);
      chk("post_rst_halt", {31'd0, halt}, 32'd0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
